// File: rtl/weight_fetch.sv
// Weight-set fetcher: reads NUM_RDATA packed words per set from a fixed-latency
// memory and streams per-kernel slices into the weight buffer, paced by full/request.
module weight_fetch #(
    parameter int DAT_WIDTH   = 8,
    parameter int NUM_KERNEL  = 4,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_RDATA   = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_start,
    input  logic [ADDR_WIDTH-1:0]                         i_base_addr,
    input  logic [CNT_WIDTH-1:0]                          i_num_set,
    output logic                                          o_mem_en,
    output logic [ADDR_WIDTH-1:0]                         o_mem_addr,
    input  logic [DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0]   i_mem_data,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]              o_data_kn0,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]              o_data_kn1,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]              o_data_kn2,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]              o_data_kn3,
    output logic                                          o_data_kn0_val,
    output logic                                          o_data_kn1_val,
    output logic                                          o_data_kn2_val,
    output logic                                          o_data_kn3_val,
    input  logic                                          i_buf_full,
    input  logic                                          i_data_req,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_err
);

    localparam int SLICE_W = DAT_WIDTH * NUM_CHANNEL;
    localparam int RD_W    = $clog2(NUM_RDATA + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, DONE} state_t;

    state_t                              state;
    logic [CNT_WIDTH-1:0]                rem;
    logic [RD_W-1:0]                     rd_cnt;
    logic [RD_W-1:0]                     inflight;
    logic [MEM_LATENCY-1:0]              vld_pipe;
    logic [NUM_KERNEL-1:0][SLICE_W-1:0]  data_q;
    logic                                data_val;

    // Control FSM; o_mem_addr doubles as the address pointer carried across sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            o_mem_en   <= 1'b0;
            o_mem_addr <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            rem        <= '0;
            rd_cnt     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_err      <= 1'b0;
                        o_mem_addr <= i_base_addr;
                        rem        <= i_num_set;
                        rd_cnt     <= '0;
                        o_busy     <= 1'b1;
                        if (i_num_set == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state    <= READ;
                            o_mem_en <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (i_data_req) o_err <= 1'b1;
                    if (rd_cnt == RD_W'(NUM_RDATA - 1)) begin
                        o_mem_en <= 1'b0;
                        rd_cnt   <= '0;
                        state    <= WAIT;
                    end else begin
                        rd_cnt     <= rd_cnt + RD_W'(1);
                        o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
                    end
                end
                WAIT: begin
                    if (i_data_req) o_err <= 1'b1;
                    if (inflight == '0 && i_buf_full) state <= HOLD;
                end
                HOLD: begin
                    if (i_data_req) begin
                        rem <= rem - CNT_WIDTH'(1);
                        if (rem == CNT_WIDTH'(1)) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state      <= READ;
                            o_mem_en   <= 1'b1;
                            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-valid tracking: read data is captured one cycle after it arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            data_val <= 1'b0;
            data_q   <= '0;
            inflight <= '0;
        end else begin
            vld_pipe[0] <= o_mem_en;
            for (int i = 1; i < MEM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            data_val <= vld_pipe[MEM_LATENCY-1];
            if (vld_pipe[MEM_LATENCY-1]) data_q <= i_mem_data;
            inflight <= inflight + RD_W'(o_mem_en) - RD_W'(data_val);
        end
    end

    assign o_data_kn0     = data_q[0];
    assign o_data_kn1     = data_q[1];
    assign o_data_kn2     = data_q[2];
    assign o_data_kn3     = data_q[3];
    assign o_data_kn0_val = data_val;
    assign o_data_kn1_val = data_val;
    assign o_data_kn2_val = data_val;
    assign o_data_kn3_val = data_val;

endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: memory and buffer models, address/latency/data scoreboard,
// a table of directed runs, hand sequences for reset and empty runs, then random runs.
module tb_weight_fetch;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_base_addr = '0;
    logic [15:0] i_num_set = '0;
    logic        o_mem_en;
    logic [15:0] o_mem_addr;
    logic [95:0] i_mem_data;
    logic [23:0] o_data_kn0, o_data_kn1, o_data_kn2, o_data_kn3;
    logic        o_data_kn0_val, o_data_kn1_val, o_data_kn2_val, o_data_kn3_val;
    logic        i_buf_full = 1'b0;
    logic        i_data_req = 1'b0;
    logic        o_busy, o_done, o_err;

    weight_fetch #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_set(i_num_set), .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
        .i_mem_data(i_mem_data),
        .o_data_kn0(o_data_kn0), .o_data_kn1(o_data_kn1),
        .o_data_kn2(o_data_kn2), .o_data_kn3(o_data_kn3),
        .o_data_kn0_val(o_data_kn0_val), .o_data_kn1_val(o_data_kn1_val),
        .o_data_kn2_val(o_data_kn2_val), .o_data_kn3_val(o_data_kn3_val),
        .i_buf_full(i_buf_full), .i_data_req(i_data_req),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] mem_word(input logic [15:0] a);
        logic [95:0] w;
        for (int j = 0; j < 12; j++) w[j*8 +: 8] = a[7:0] * 8'd3 + 8'(j * 29) + a[15:8];
        return w;
    endfunction

    // Memory: fixed-latency read, garbage when no read is returning.
    logic [95:0]  rd_d [L];
    logic [L-1:0] rd_v = '0;
    always @(posedge clk) begin
        rd_v[0] <= o_mem_en;
        rd_d[0] <= mem_word(o_mem_addr);
        for (int i = 1; i < L; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_d[i] <= rd_d[i-1];
        end
    end
    assign i_mem_data = rd_v[L-1] ? rd_d[L-1] : {12{8'hA5}};

    // Buffer: full after three slices; a request only empties a full buffer.
    logic [1:0] bcnt = '0;
    always @(posedge clk) begin
        if (rst) bcnt <= '0;
        else if (i_data_req && bcnt == 2'd3) bcnt <= '0;
        else if (o_data_kn0_val && bcnt != 2'd3) bcnt <= bcnt + 2'd1;
    end

    logic [15:0] exp_addr[$];
    logic [15:0] rd_q[$];
    int          rc_q[$];
    int cyc, n_chk, n_fail, n_val, n_en, n_done, first_rd, bp_bad, land, last_t_done;
    bit bp_hold;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic monitor();
        logic [15:0] a;
        logic [95:0] w;
        int c;
        if (o_mem_en === 1'b1) begin
            n_en++;
            if (first_rd < 0) first_rd = cyc;
            if (bp_hold && land >= 0) bp_bad++;
            if (exp_addr.size() == 0) fail_now("extra_read");
            else chk("rd_addr", 64'(o_mem_addr), 64'(exp_addr.pop_front()));
            rd_q.push_back(o_mem_addr);
            rc_q.push_back(cyc);
        end
        if ((o_data_kn0_val | o_data_kn1_val | o_data_kn2_val | o_data_kn3_val) === 1'b1) begin
            n_val++;
            chk("val_same", 64'({o_data_kn0_val, o_data_kn1_val, o_data_kn2_val, o_data_kn3_val}), 64'(4'hF));
            if (rd_q.size() == 0) fail_now("valid_without_read");
            else begin
                a = rd_q.pop_front();
                c = rc_q.pop_front();
                w = mem_word(a);
                chk("latency", 64'(cyc - c), 64'(L + 1));
                chk("kn0", 64'(o_data_kn0), 64'(w[23:0]));
                chk("kn1", 64'(o_data_kn1), 64'(w[47:24]));
                chk("kn2", 64'(o_data_kn2), 64'(w[71:48]));
                chk("kn3", 64'(o_data_kn3), 64'(w[95:72]));
            end
        end
        if (o_done === 1'b1) n_done++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        i_buf_full = (bcnt == 2'd3) && !bp_hold;
        monitor();
    endtask

    task automatic clear_sb();
        exp_addr.delete();
        rd_q.delete();
        rc_q.delete();
        n_val = 0; n_en = 0; n_done = 0; first_rd = -1; bp_bad = 0; land = -1;
    endtask

    // One complete fetch; expected addresses are base .. base+3n-1 in order.
    task automatic run(input logic [15:0] base, input int n, input int dly, input int bp,
                       input bit errp, input bit exp_err, input string tag);
        int fcnt, sets_done, t_req, t_done, budget, first_full;
        clear_sb();
        for (int i = 0; i < 3 * n; i++) exp_addr.push_back(base + 16'(i));
        bp_hold = (bp > 0);
        i_base_addr = base; i_num_set = 16'(n); i_start = 1'b1; cyc = 0;
        step();
        i_start = 1'b0;
        chk({tag, "_err_clr"}, 64'(o_err), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(1));
        fcnt = 0; sets_done = 0; t_req = -1; t_done = -1; budget = 0; first_full = -1;
        while (budget < 100 * n + 100) begin
            if (t_req >= 0 && cyc == t_req + 1) begin
                if (sets_done < n) chk({tag, "_read_after_req"}, 64'(o_mem_en), 64'(1));
                else begin
                    chk({tag, "_done_pulse"}, 64'(o_done), 64'(1));
                    t_done = cyc;
                end
            end
            if (t_done >= 0 && cyc == t_done + 1) begin
                chk({tag, "_busy_fall"}, 64'(o_busy), 64'(0));
                chk({tag, "_done_one_cycle"}, 64'(o_done), 64'(0));
                break;
            end
            if (errp && cyc == 6) chk({tag, "_err_set"}, 64'(o_err), 64'(1));
            if (land < 0 && n_val == 3) land = cyc;
            if (bp_hold && land >= 0 && cyc >= land + bp) begin
                bp_hold = 1'b0;
                i_buf_full = (bcnt == 2'd3);
            end
            if (i_buf_full) begin
                if (first_full < 0) first_full = cyc;
                fcnt++;
            end else fcnt = 0;
            i_start = (cyc == 2);
            if (cyc == 2) begin
                i_base_addr = 16'hFFF0;
                i_num_set = 16'd0;
            end
            i_data_req = (fcnt == dly + 1) || (errp && cyc == 5);
            if (fcnt == dly + 1) begin
                t_req = cyc;
                sets_done++;
            end
            step();
            i_data_req = 1'b0;
            i_start = 1'b0;
            budget++;
        end
        if (t_done < 0) fail_now({tag, "_timeout"});
        last_t_done = t_done;
        chk({tag, "_nval"}, 64'(n_val), 64'(3 * n));
        chk({tag, "_nen"}, 64'(n_en), 64'(3 * n));
        chk({tag, "_ndone"}, 64'(n_done), 64'(1));
        chk({tag, "_addr_left"}, 64'(exp_addr.size()), 64'(0));
        chk({tag, "_err_final"}, 64'(o_err), 64'(exp_err));
        chk({tag, "_first_rd"}, 64'(first_rd), 64'(1));
        chk({tag, "_no_rd_in_bp"}, 64'(bp_bad), 64'(0));
        if (bp == 0) chk({tag, "_full_cycle"}, 64'(first_full), 64'(5 + L));
    endtask

    typedef struct {
        logic [15:0] base;
        int          n;
        int          dly;
        int          bp;
        bit          errp;
        bit          exp_err;
        string       tag;
    } vec_t;

    vec_t tv[5];

    initial begin
        tv[0] = '{16'h0010, 1, 3, 0,  1'b0, 1'b0, "basic"};
        tv[1] = '{16'h0010, 3, 1, 0,  1'b0, 1'b0, "multi"};
        tv[2] = '{16'h0020, 2, 2, 0,  1'b1, 1'b1, "err_wait"};
        tv[3] = '{16'h0030, 1, 1, 20, 1'b0, 1'b0, "backpress"};
        tv[4] = '{16'h0050, 2, 1, 0,  1'b0, 1'b0, "after_err"};
        n_chk = 0; n_fail = 0; cyc = 0; bp_hold = 1'b0;
        clear_sb();

        repeat (3) step();
        chk("rst_en", 64'(o_mem_en), 64'(0));
        chk("rst_addr", 64'(o_mem_addr), 64'(0));
        chk("rst_busy_done_err", 64'({o_busy, o_done, o_err}), 64'(0));
        chk("rst_val", 64'(o_data_kn0_val), 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run(tv[i].base, tv[i].n, tv[i].dly, tv[i].bp, tv[i].errp, tv[i].exp_err, tv[i].tag);
            if (i == 0) chk("basic_done_cycle", 64'(last_t_done), 64'(11));
            repeat (2) step();
        end

        // Empty run: straight to DONE.
        clear_sb();
        i_num_set = 16'd0; i_base_addr = 16'h0070; i_start = 1'b1; cyc = 0;
        step();
        i_start = 1'b0;
        chk("zero_done", 64'(o_done), 64'(1));
        chk("zero_busy", 64'(o_busy), 64'(1));
        chk("zero_en", 64'(o_mem_en), 64'(0));
        step();
        chk("zero_done_fall", 64'(o_done), 64'(0));
        chk("zero_busy_fall", 64'(o_busy), 64'(0));
        repeat (3) step();
        chk("zero_nen", 64'(n_en), 64'(0));
        chk("zero_ndone", 64'(n_done), 64'(1));

        // Reset two cycles after the first read: in-flight reads must vanish.
        clear_sb();
        for (int i = 0; i < 3; i++) exp_addr.push_back(16'h0040 + 16'(i));
        i_num_set = 16'd2; i_base_addr = 16'h0040; i_start = 1'b1; cyc = 0;
        step();
        i_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        clear_sb();
        step();
        rst = 1'b0;
        chk("midrst_en", 64'(o_mem_en), 64'(0));
        chk("midrst_addr", 64'(o_mem_addr), 64'(0));
        chk("midrst_flags", 64'({o_busy, o_done, o_err}), 64'(0));
        chk("midrst_data", 64'({o_data_kn0_val, o_data_kn0}), 64'(0));
        repeat (10) step();
        chk("midrst_nval", 64'(n_val), 64'(0));
        chk("midrst_nen", 64'(n_en), 64'(0));
        chk("midrst_busy", 64'(o_busy), 64'(0));
        run(16'h0044, 1, 1, 0, 1'b0, 1'b0, "post_rst");
        repeat (2) step();

        for (int r = 0; r < 6; r++) begin
            run(16'($urandom_range(0, 16'hF000)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 3)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
                1'b0, 1'b0, "rand");
            repeat (2) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_fetch.md
# weight_fetch

Upstream feeder for the 4-kernel × 3-channel × 3-position weight buffer. It reads packed weight words from an on-chip weight memory (BRAM, fixed read latency) and streams them into the buffer's per-kernel input ports. It fetches one full weight set (NUM_RDATA words), waits until the buffer reports full, then waits for the consumer's data request before fetching the next set, for a programmed number of sets.

## Interface
Parameters:
- DAT_WIDTH, 8, bits per weight element
- NUM_KERNEL, 4, kernels per memory word; fixed at 4 by the port list
- NUM_CHANNEL, 3, channels per kernel slice
- NUM_RDATA, 3, words per weight set
- ADDR_WIDTH, 16, memory address width
- CNT_WIDTH, 16, set counter width
- MEM_LATENCY, 2, memory read latency in cycles; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  address of set 0, row 0; latched on accepted start
- i_num_set  in  CNT_WIDTH  number of sets to fetch; latched on accepted start
- o_mem_en  out  1  memory read enable
- o_mem_addr  out  ADDR_WIDTH  memory read address
- i_mem_data  in  DAT_WIDTH·NUM_CHANNEL·NUM_KERNEL  read data, valid MEM_LATENCY cycles after o_mem_en
- o_data_kn0..o_data_kn3  out  DAT_WIDTH·NUM_CHANNEL each  kernel slices to the buffer
- o_data_kn0_val..o_data_kn3_val  out  1 each  slice valid; all four are identical
- i_buf_full  in  1  buffer full flag
- i_data_req  in  1  consumer request; the same signal the buffer sees
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the last set has been consumed
- o_err  out  1  sticky protocol error

## Operation
- Memory layout:
  - Set s, row r is at address base + s·NUM_RDATA + r.
  - Word bits [k·24 +: 24] hold kernel k (24 = DAT_WIDTH·NUM_CHANNEL).
  - Row 0 is fetched first.
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - On i_start, latch base and count and clear o_err.
  - If count = 0, go to DONE; otherwise go to READ.
- READ:
  - Assert o_mem_en for exactly NUM_RDATA consecutive cycles at consecutive addresses.
  - The address pointer persists across sets; there is no gap between sets.
  - Then go to WAIT.
- WAIT: go to HOLD when the in-flight counter is 0 and i_buf_full = 1.
- HOLD:
  - On i_data_req, decrement the remaining-set count.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: assert o_done for one cycle, then go to IDLE.
- Data path:
  - A MEM_LATENCY-deep shift register tracks o_mem_en.
  - Its output registers i_mem_data into o_data_kn* and sets the valids one cycle later.
  - The in-flight counter increments on o_mem_en and decrements on each o_data_kn*_val; its range is 0..NUM_RDATA.
- Errors:
  - i_data_req in READ or WAIT sets o_err, because the buffer would drop a partial set.
  - The fetch itself continues unchanged.
  - i_start outside IDLE is ignored.
- Reset:
  - All outputs go to 0, the FSM to IDLE, and the counters and valid pipeline are cleared.
  - Reads already in flight at reset never produce a valid.

## Timing
- Read-to-valid latency: MEM_LATENCY+1 cycles from o_mem_en to o_data_kn*_val.
- HOLD→READ fires on the request cycle t, so the first new read is issued in t+1 and the first valid lands at ≥ t+3.
  - This is after the buffer's valid clear at the end of t+1, which is required and guaranteed for MEM_LATENCY ≥ 1.
- With start at cycle 0:
  - Reads are issued in cycles 1–3.
  - Valids appear in cycles 2+L..4+L (L = MEM_LATENCY).
  - The buffer's full flag rises in 5+L.
  - HOLD is entered in 6+L.
- o_done is high in the cycle after the final request is accepted.
- o_busy falls the following cycle.
- Valids are only ever asserted in READ or WAIT, and never in HOLD.

## Test plan
- Basic run, L=2, base=0x10, num_set=1, start at cycle 0:
  - Reads hit 0x10, 0x11, 0x12 in cycles 1–3 and valids appear in cycles 4–6.
  - o_data_kn2 equals bits [71:48] of each word.
  - With a buffer model attached, full rises at cycle 7.
  - Request at cycle 10 → o_done at cycle 11.
- Multi-set, num_set=3:
  - Addresses run 0x10..0x18 with no repeats.
  - Each new READ begins exactly one cycle after its request.
  - Exactly 9 valid pulses are produced and exactly one o_done.
- num_set=0: o_done at cycle 1, o_mem_en never asserted, o_busy high for one cycle only.
- i_data_req pulsed during WAIT: o_err goes 1 and stays 1 until the next accepted start; the fetch completes normally.
- rst asserted two cycles after the first read: no valids at all afterwards, all outputs 0, FSM in IDLE, and a fresh start works.
- Back-pressure: hold i_buf_full at 0 for 20 cycles after the data lands. The block stays in WAIT with no reads, then enters HOLD one cycle after full rises.
